// File: rtl/rtlola_cycle_offset_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtlola_cycle_offset_monitor: 4-phase time-multiplexed RTLola monitor for
// a = x + c[-1|0], b = a[-1|0] + a, c = b.   Rev 1.0
// ---------------------------------------------------------------------------
module rtlola_cycle_offset_monitor (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [63:0] x,
  input  logic               newX,
  output logic               outputPhase,
  output logic signed [63:0] a,
  output logic               enA,
  output logic signed [63:0] b,
  output logic               enB,
  output logic signed [63:0] c,
  output logic               enC
);

  localparam logic [1:0] C_PH_CAPTURE = 2'd0;
  localparam logic [1:0] C_PH_EVAL_A  = 2'd1;
  localparam logic [1:0] C_PH_EVAL_B  = 2'd2;

  logic [1:0]         phase_q, phase_d;
  logic               event_q, event_d;
  logic signed [63:0] xcap_q, xcap_d;
  logic signed [63:0] a_q, a_d;
  logic signed [63:0] b_q, b_d;
  logic signed [63:0] c_q, c_d;
  logic signed [63:0] prev_a_q, prev_a_d;
  logic signed [63:0] prev_c_q, prev_c_d;
  logic               out_q, out_d;
  logic               upd_q, upd_d;

  always_comb begin
    phase_d  = phase_q;
    event_d  = event_q;
    xcap_d   = xcap_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    prev_a_d = prev_a_q;
    prev_c_d = prev_c_q;
    out_d    = out_q;
    upd_d    = upd_q;
    if (en) begin
      phase_d = phase_q + 2'd1;
      // Output flags are registered so they appear during the next frame's phase 0.
      out_d   = (phase_q == 2'd3);
      upd_d   = (phase_q == 2'd3) && event_q;
      case (phase_q)
        C_PH_CAPTURE: begin
          event_d = newX;
          if (newX) xcap_d = x;
        end
        C_PH_EVAL_A: if (event_q) a_d = xcap_q + prev_c_q;
        C_PH_EVAL_B: if (event_q) b_d = prev_a_q + a_q;
        default: begin
          // History moves only once the whole event is evaluated.
          if (event_q) begin
            c_d      = b_q;
            prev_a_d = a_q;
            prev_c_d = b_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= 2'd0;
      event_q  <= 1'b0;
      xcap_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      prev_a_q <= '0;
      prev_c_q <= '0;
      out_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      event_q  <= event_d;
      xcap_q   <= xcap_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      prev_a_q <= prev_a_d;
      prev_c_q <= prev_c_d;
      out_q    <= out_d;
      upd_q    <= upd_d;
    end
  end

  assign outputPhase = out_q;
  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign enA         = upd_q;
  assign enB         = upd_q;
  assign enC         = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_rtlola_cycle_offset_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rtlola_cycle_offset_monitor: directed + random frames vs. stream model.
// ---------------------------------------------------------------------------
module tb_rtlola_cycle_offset_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic [63:0] x = '0;
  logic        newX = 1'b0;
  logic        outputPhase, enA, enB, enC;
  logic [63:0] a, b, c;

  int n_checks = 0;
  int n_errors = 0;

  // Stream-level model: last values and the one-event-back history.
  logic [63:0] m_a, m_b, m_c, m_pa, m_pc;

  rtlola_cycle_offset_monitor dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .newX(newX),
    .outputPhase(outputPhase),
    .a(a), .enA(enA), .b(b), .enB(enB), .c(c), .enC(enC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_a = '0; m_b = '0; m_c = '0; m_pa = '0; m_pc = '0;
  endtask

  task automatic model_event(input logic [63:0] xv);
    m_a  = xv + m_pc;
    m_b  = m_pa + m_a;
    m_c  = m_b;
    m_pa = m_a;
    m_pc = m_c;
  endtask

  task automatic check_outputs(input bit ev);
    chk("outputPhase", {63'd0, outputPhase}, 64'd1);
    chk("enA", {63'd0, enA}, {63'd0, ev});
    chk("enB", {63'd0, enB}, {63'd0, ev});
    chk("enC", {63'd0, enC}, {63'd0, ev});
    chk("a", a, m_a);
    chk("b", b, m_b);
    chk("c", c, m_c);
  endtask

  // Entered just after an edge with the DUT at phase 0; leaves at phase 0.
  task automatic frame(input bit ev, input logic [63:0] xv, input bit late, input int stall);
    newX = ev & ~late;
    x    = xv;
    en   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        chk("op_mid", {63'd0, outputPhase}, 64'd0);
        chk("enA_mid", {63'd0, enA}, 64'd0);
      end
      if (late && k == 0) newX = 1'b1;
      if (late && k == 2) newX = 1'b0;
      if (stall > 0 && k == 1) begin
        en = 1'b0;
        repeat (stall) begin
          @(posedge clk); #1;
          chk("op_stall", {63'd0, outputPhase}, 64'd0);
        end
        en = 1'b1;
      end
    end
    if (ev && !late) model_event(xv);
    check_outputs(ev && !late);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    chk("rst_a", a, 64'd0);
    chk("rst_b", b, 64'd0);
    chk("rst_c", c, 64'd0);
    chk("rst_op", {63'd0, outputPhase}, 64'd0);
    chk("rst_enA", {63'd0, enA}, 64'd0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
    newX = 1'b0;
    en = 1'b1;
    model_clear();
  endtask

  initial begin
    model_clear();
    @(posedge clk); #1;
    do_reset(10);

    // Idle frames: pulse every frame, nothing computed.
    repeat (3) frame(1'b0, 64'd9, 1'b0, 0);

    // Six spaced x=1 events with idle frames between; one mid-frame stall.
    for (int i = 0; i < 6; i++) begin
      frame(1'b1, 64'd1, 1'b0, (i == 2) ? 3 : 0);
      frame(1'b0, 64'd5, 1'b0, 0);
      frame(1'b0, 64'd6, (i == 4), 0);
    end
    chk("seq_a", a, 64'd20);
    chk("seq_b", b, 64'd32);

    // Wrap-around.
    do_reset(3);
    frame(1'b1, 64'd1, 1'b0, 0);
    frame(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 0);
    chk("wrap_a", a, 64'h8000_0000_0000_0000);
    chk("wrap_b", b, 64'h8000_0000_0000_0001);

    // newX held 8 cycles -> two events.
    do_reset(2);
    frame(1'b1, 64'd1, 1'b0, 0);
    frame(1'b1, 64'd1, 1'b0, 0);
    chk("hold_b", b, 64'd3);

    // Mid-frame reset after two events clears history.
    frame(1'b0, 64'd0, 1'b0, 0);
    newX = 1'b1; x = 64'd5;
    repeat (2) begin @(posedge clk); #1; end
    do_reset(2);
    frame(1'b1, 64'd1, 1'b0, 0);
    chk("post_rst_a", a, 64'd1);

    // Random frames.
    for (int i = 0; i < 40; i++) begin
      bit ev;
      bit late;
      ev   = ($urandom_range(0, 2) != 0);
      late = !ev && ($urandom_range(0, 3) == 0);
      frame(ev, {$urandom(), $urandom()}, late, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
